// File: rtl/sram_pkg.sv
// Shared types for the dual-port byte-masked SRAM.
// Holds the clear-FSM states and the read-during-write mode encodings.
package sram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

endpackage

// File: rtl/sram_dp_bytemask_if.sv
// Read port A, byte-masked write port B and BUSY status of the dual-port SRAM.
// master drives requests; slave (the SRAM) returns read data and status.
interface sram_dp_bytemask_if #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  CENA;
  logic [ADDR_WIDTH-1:0] AA;
  logic [BITS-1:0]       QA;
  logic                  QVALID;
  logic                  CENB;
  logic [ADDR_WIDTH-1:0] AB;
  logic [BITS-1:0]       DB;
  logic [BITS/8-1:0]     BWENB;
  logic                  BUSY;

  modport master (
    output CENA, AA, CENB, AB, DB, BWENB,
    input  QA, QVALID, BUSY
  );

  modport slave (
    input  CENA, AA, CENB, AB, DB, BWENB,
    output QA, QVALID, BUSY
  );

endinterface

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle, then parks in READY until reset.
// Latency: WORD_DEPTH+1 busy cycles after reset release.
// Backpressure: none; busy tells the top to ignore port requests.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  localparam logic [ADDR_WIDTH:0] LAST = WORD_DEPTH[ADDR_WIDTH:0];

  clr_state_t          state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter runs one past the last word so READY starts a cycle after the final clear.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q[ADDR_WIDTH-1:0];
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          clr_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/sram_dp_bytemask.sv
// Dual-port SRAM, byte-masked write port B, read port A, zero-clear after reset.
// Read latency 1 cycle, or 2 when SRAM_OUT_REG_EN is defined.
// Backpressure: none; requests are ignored while BUSY is high.
module sram_dp_bytemask
  import sram_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = RDW_OLD
) (
  input logic               CLK,
  input logic               RST,
  sram_dp_bytemask_if.slave mem_if
);

  localparam int                  NBYTES = BITS / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH  = WORD_DEPTH[ADDR_WIDTH:0];

  logic [BITS-1:0] mem [WORD_DEPTH];

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_seq #(
    .WORD_DEPTH (WORD_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear (
    .CLK      (CLK),
    .RST      (RST),
    .busy     (busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  assign mem_if.BUSY = busy;

  logic rd_in_range, wr_in_range, collide;
  logic [BITS-1:0] wr_old, wr_merged, rd_word;

  assign rd_in_range = ({1'b0, mem_if.AA} < DEPTH);
  assign wr_in_range = ({1'b0, mem_if.AB} < DEPTH);
  assign collide     = !mem_if.CENB && (mem_if.AA == mem_if.AB);

  always_comb begin
    wr_old    = wr_in_range ? mem[mem_if.AB] : '0;
    wr_merged = wr_old;
    for (int k = 0; k < NBYTES; k++) begin
      if (!mem_if.BWENB[k]) wr_merged[8*k +: 8] = mem_if.DB[8*k +: 8];
    end
  end

  // A colliding read sees the merged word only in new-data mode.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (collide && (RDW_MODE == RDW_NEW)) rd_word = wr_merged;
      else                                  rd_word = mem[mem_if.AA];
    end
  end

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [BITS-1:0]       mem_wd;

  assign mem_we = busy ? clr_we   : (!mem_if.CENB && wr_in_range);
  assign mem_wa = busy ? clr_addr : mem_if.AB;
  assign mem_wd = busy ? '0       : wr_merged;

  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem[mem_wa] <= mem_wd;
  end

  logic [BITS-1:0] q1;
  logic            v1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else if (busy || mem_if.CENA) begin
      v1 <= 1'b0;
    end else begin
      q1 <= rd_word;
      v1 <= 1'b1;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [BITS-1:0] q2;
  logic            v2;

  always_ff @(posedge CLK) begin
    if (RST) begin
      q2 <= '0;
      v2 <= 1'b0;
    end else begin
      q2 <= q1;
      v2 <= v1;
    end
  end

  assign mem_if.QA     = q2;
  assign mem_if.QVALID = v2;
`else
  assign mem_if.QA     = q1;
  assign mem_if.QVALID = v1;
`endif

endmodule

// File: tb/tb_sram_dp_bytemask.sv
// Bench for sram_dp_bytemask: two instances (depth 8 old-data, depth 6 new-data) share one stimulus.
// A per-cycle word-array model checks both; directed reads pin literal values.
`timescale 1ns/1ps
module tb_sram_dp_bytemask;
  import sram_pkg::*;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic        cena  = 1'b1;
  logic        cenb  = 1'b1;
  logic [2:0]  aa    = '0;
  logic [2:0]  ab    = '0;
  logic [31:0] db    = '0;
  logic [3:0]  bwenb = 4'hF;
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  sram_dp_bytemask_if #(.BITS(32), .ADDR_WIDTH(4)) if_a ();
  sram_dp_bytemask_if #(.BITS(32), .ADDR_WIDTH(3)) if_b ();

  assign if_a.CENA  = cena;
  assign if_a.AA    = {1'b0, aa};
  assign if_a.CENB  = cenb;
  assign if_a.AB    = {1'b0, ab};
  assign if_a.DB    = db;
  assign if_a.BWENB = bwenb;
  assign if_b.CENA  = cena;
  assign if_b.AA    = aa;
  assign if_b.CENB  = cenb;
  assign if_b.AB    = ab;
  assign if_b.DB    = db;
  assign if_b.BWENB = bwenb;

  sram_dp_bytemask #(.BITS(32), .WORD_DEPTH(8), .ADDR_WIDTH(4), .RDW_MODE(RDW_OLD)) u_a (
    .CLK (CLK), .RST (RST), .mem_if (if_a.slave)
  );
  sram_dp_bytemask #(.BITS(32), .WORD_DEPTH(6), .ADDR_WIDTH(3), .RDW_MODE(RDW_NEW)) u_b (
    .CLK (CLK), .RST (RST), .mem_if (if_b.slave)
  );

  // Model: word array per instance, busy-cycle countdown, and the read result delayed by LAT edges.
  int          dep [2] = '{8, 6};
  int          rdw [2] = '{RDW_OLD, RDW_NEW};
  int          clr_left [2] = '{0, 0};
  logic [31:0] m_mem [2][8];
  logic [31:0] pq [2][2];
  logic        pv [2][2];
  logic [31:0] m_rq;
  logic        m_rv;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be_n);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (!be_n[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (RST) begin
        clr_left[i] = dep[i] + 1;
        for (int w = 0; w < 8; w++) m_mem[i][w] = '0;
        for (int s = 0; s < 2; s++) begin
          pq[i][s] = '0;
          pv[i][s] = 1'b0;
        end
      end else begin
        m_rv = 1'b0;
        m_rq = pq[i][0];
        if (clr_left[i] > 0) begin
          clr_left[i] = clr_left[i] - 1;
        end else begin
          if (!cena) begin
            m_rv = 1'b1;
            if (int'(aa) >= dep[i])                          m_rq = '0;
            else if (!cenb && ab == aa && rdw[i] == RDW_NEW) m_rq = merge(m_mem[i][aa], db, bwenb);
            else                                             m_rq = m_mem[i][aa];
          end
          if (!cenb && int'(ab) < dep[i]) m_mem[i][ab] = merge(m_mem[i][ab], db, bwenb);
        end
        pq[i][1] = pq[i][0];
        pv[i][1] = pv[i][0];
        pq[i][0] = m_rq;
        pv[i][0] = m_rv;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("busy_a",   {31'b0, if_a.BUSY},   {31'b0, clr_left[0] > 0});
      check("busy_b",   {31'b0, if_b.BUSY},   {31'b0, clr_left[1] > 0});
      check("qvalid_a", {31'b0, if_a.QVALID}, {31'b0, pv[0][LAT-1]});
      check("qvalid_b", {31'b0, if_b.QVALID}, {31'b0, pv[1][LAT-1]});
      check("qa_a",     if_a.QA,              pq[0][LAT-1]);
      check("qa_b",     if_b.QA,              pq[1][LAT-1]);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cena  = 1'b1;
    cenb  = 1'b1;
    bwenb = 4'hF;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be_n);
    cenb = 1'b0; ab = a; db = d; bwenb = be_n;
    tick();
    idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp_a, input logic [31:0] exp_b);
    cena = 1'b0; aa = a;
    tick();
    idle();
    for (int c = 1; c < LAT; c++) tick();
    check("rd_vld_a", {31'b0, if_a.QVALID}, 32'd1);
    check("rd_vld_b", {31'b0, if_b.QVALID}, 32'd1);
    check("rd_qa_a",  if_a.QA, exp_a);
    check("rd_qa_b",  if_b.QA, exp_b);
  endtask

  task automatic count_busy(input string tag);
    int ba = 0;
    int bb = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (if_a.BUSY) ba++;
      if (if_b.BUSY) bb++;
    end
    check({tag, "_busy_cycles_a"}, ba, 32'd9);
    check({tag, "_busy_cycles_b"}, bb, 32'd7);
    tick();
  endtask

  initial begin
    RST = 1'b1;
    idle();
    tick();
    chk_en = 1'b1;
    check("rst_busy_a",  {31'b0, if_a.BUSY},   32'd1);
    check("rst_qvld_a",  {31'b0, if_a.QVALID}, 32'd0);
    check("rst_qa_b",    if_b.QA,              32'd0);
    tick();
    RST = 1'b0;
    count_busy("clear");

    for (int a = 0; a < 8; a++) rd(a[2:0], 32'h0, 32'h0);

    wr(3'd3, 32'hAABBCCDD, 4'b0000);
    wr(3'd3, 32'h11223344, 4'b1010);
    rd(3'd3, 32'hAA22CC44, 32'hAA22CC44);
    wr(3'd3, 32'hFFFFFFFF, 4'b1111);
    rd(3'd3, 32'hAA22CC44, 32'hAA22CC44);

    cena = 1'b0; aa = 3'd5;
    cenb = 1'b0; ab = 3'd5; db = 32'hFFFF0000; bwenb = 4'b0000;
    tick();
    idle();
    for (int c = 1; c < LAT; c++) tick();
    check("coll_old_a", if_a.QA, 32'h00000000);
    check("coll_new_b", if_b.QA, 32'hFFFF0000);
    rd(3'd5, 32'hFFFF0000, 32'hFFFF0000);

    wr(3'd2, 32'h12345678, 4'b0000);
    cena = 1'b0; aa = 3'd2;
    tick();
    idle();
    for (int c = 1; c <= LAT; c++) begin
      check("lat_vld_a", {31'b0, if_a.QVALID}, {31'b0, c == LAT});
      if (c < LAT) tick();
    end
    check("lat_qa_a", if_a.QA, 32'h12345678);
    tick();
    tick();
    check("hold_vld_a", {31'b0, if_a.QVALID}, 32'd0);
    check("hold_qa_a",  if_a.QA,              32'h12345678);

    wr(3'd7, 32'h5555AAAA, 4'b0000);
    wr(3'd6, 32'h0BADF00D, 4'b0000);
    rd(3'd7, 32'h5555AAAA, 32'h0);
    rd(3'd6, 32'h0BADF00D, 32'h0);

    RST = 1'b1;
    tick();
    RST = 1'b0;
    cena = 1'b0; aa = 3'd1;
    cenb = 1'b0; ab = 3'd1; db = 32'hDEADBEEF; bwenb = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
    check("midclr_vld_a", {31'b0, if_a.QVALID}, 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    idle();
    count_busy("restart");
    rd(3'd1, 32'h0, 32'h0);
    rd(3'd2, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_bytemask.md
SRAM_DP_BYTEMASK -- requirements
Module: sram_dp_bytemask

Interface
REQ-001 Parameter BITS, default 32: data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter WORD_DEPTH, default 1024: number of words; need not be a power of two.
REQ-003 Parameter ADDR_WIDTH, default 10: address width; SHALL satisfy 2**ADDR_WIDTH >= WORD_DEPTH.
REQ-004 Parameter RDW_MODE, default 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.
REQ-005 Clock and reset: one clock, CLK; reset RST is synchronous and active-high.
REQ-006 CLK  input  1  clock; all state changes on its rising edge.
REQ-007 RST  input  1  synchronous active-high reset.
REQ-008 CENA  input  1  read-port enable; 0 = read, 1 = standby.
REQ-009 AA  input  ADDR_WIDTH  read address.
REQ-010 QA  output  BITS  read data.
REQ-011 QVALID  output  1  high for one cycle when QA carries fresh read data.
REQ-012 CENB  input  1  write-port enable; 0 = write, 1 = standby.
REQ-013 AB  input  ADDR_WIDTH  write address.
REQ-014 DB  input  BITS  write data.
REQ-015 BWENB  input  BITS/8  byte write enables, active-low; bit k covers DB[8k+7:8k].
REQ-016 BUSY  output  1  high while the post-reset clear sequence runs.

Function
REQ-017 The two ports SHALL operate independently in the same cycle: one read on port A and one write on port B.
REQ-018 Write: when CENB=0 and BUSY=0, each byte k with BWENB[k]=0 SHALL take DB at mem[AB]; bytes with BWENB[k]=1 SHALL keep their value; all-ones BWENB SHALL be a no-op.
REQ-019 Read: when CENA=0 and BUSY=0, QA SHALL present mem[AA] one cycle later with QVALID=1; otherwise QA SHALL hold its value and QVALID=0.
REQ-020 Collision (CENA=0, CENB=0, AA==AB): with RDW_MODE=0, QA SHALL be the pre-write word; with RDW_MODE=1, QA SHALL be the byte-merged post-write word.
REQ-021 Out-of-range address (>= WORD_DEPTH): the write SHALL be dropped; the read SHALL return 0 with QVALID=1.
REQ-022 Clear FSM states: CLEAR and READY. CLEAR SHALL write 0 to one word per cycle from address 0 up to WORD_DEPTH-1, then go to READY on the next cycle. READY SHALL be held until RST.
REQ-023 BUSY SHALL be 1 in CLEAR and 0 in READY; port requests made in CLEAR SHALL be ignored, with no write, QVALID=0 and QA held.

Reset
REQ-024 RST=1 SHALL set: state CLEAR, clear counter 0, QA 0, QVALID 0, BUSY 1. The first READY cycle SHALL be WORD_DEPTH+1 cycles after RST is released.
REQ-025 RST asserted in either state, including mid-clear, SHALL restart the clear sequence from address 0. Any write in the same cycle as RST SHALL be dropped.

Configuration
REQ-026 Macro SRAM_OUT_REG_EN: when defined, a second output register stage SHALL be added, so read latency is 2 cycles. QVALID SHALL be delayed to match, and both stages SHALL reset to 0.
REQ-027 Without SRAM_OUT_REG_EN, read latency SHALL be 1 cycle. The collision rules of REQ-020 SHALL hold in both configurations, judged at the cycle of the request.

Structure
REQ-028 Shared package sram_pkg SHALL hold the clear-FSM state typedef (CLEAR, READY) and the RDW_MODE constants RDW_OLD=0 and RDW_NEW=1.
REQ-029 The clear FSM and its counter SHALL be a sub-module named sram_clear_seq. It outputs BUSY plus a write address and write strobe, which are muxed onto the write port in the top level.

Verification
REQ-030 Clear: pulse RST, with WORD_DEPTH=8 -> BUSY=1 for exactly 9 cycles after release, then a read of every address returns 0.
REQ-031 Byte mask: write 0xAABBCCDD to addr 3 with BWENB=0000, then write 0x11223344 with BWENB=1010 -> reading addr 3 returns 0xAA22CC44.
REQ-032 Collision: mem[5]=0x0, same-cycle write 0xFFFF0000 and read of addr 5 -> QA=0x0 when RDW_MODE=0, QA=0xFFFF0000 when RDW_MODE=1.
REQ-033 Latency: read addr 2 holding 0x12345678 -> QVALID and QA=0x12345678 appear 1 cycle later, or 2 cycles later with SRAM_OUT_REG_EN; QA then holds with QVALID=0 while CENA=1.
REQ-034 Mid-clear reset and out-of-range: RST reasserted at counter=4 -> clear restarts at 0 with full duration. With WORD_DEPTH=6, a write to addr 7 changes nothing and a read of addr 7 returns 0.
